dense_layer_sequencer: RTL and testbench

- Flow-control wrapper that sequences one fixed-latency dense layer instance (input register -> shift-add multipliers -> adder tree -> bias -> output register).
- The dense datapath has no stall. This block gives it a valid/ready front end and a valid/ready back end.
- Tracks in-flight samples with a LATENCY-deep valid pipe and captures results into a small FIFO.
- Credit-throttles input acceptance so the FIFO can never overflow. Sits between the previous layer/activation and the next layer.

---
 rtl/dense_layer_sequencer_pkg.sv | 15 +
 rtl/dense_layer_sequencer_if.sv | 25 ++
 rtl/dense_layer_sequencer_fifo.sv | 63 ++++++
 rtl/dense_layer_sequencer.sv | 109 ++++++++++
 tb/tb_dense_layer_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_layer_sequencer_pkg.sv
// Shared types and sizing helpers for the dense layer sequencer and its result FIFO.
package dense_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } seq_state_t;

   // Width needed to hold a count from 0 to depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// Upstream and downstream valid/ready streams around the dense layer sequencer.
interface dense_layer_sequencer_if #(
   parameter int WIDTH       = 17,
   parameter int INPUT_SIZE  = 32,
   parameter int OUTPUT_SIZE = 1
);

   logic                          in_valid;
   logic                          in_ready;
   logic [WIDTH*INPUT_SIZE-1:0]   in_data;
   logic                          out_valid;
   logic                          out_ready;
   logic [WIDTH*OUTPUT_SIZE-1:0]  out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/dense_layer_sequencer_fifo.sv
// First-word-fall-through result FIFO with occupancy output and drop-on-full error pulse.
module seq_fifo
   import dense_seq_pkg::*;
#(
   parameter  int DW    = 17,
   parameter  int DEPTH = 4,
   localparam int CW    = occ_width(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic [CW-1:0] occupancy,
   output logic          full,
   output logic          empty,
   output logic          drop
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign empty    = (occupancy == '0);
   assign full     = (occupancy == FULL_OCC);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign drop     = push && !do_push;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   occupancy <= occupancy + CW'(1);
            2'b01:   occupancy <= occupancy - CW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // NOTE: storage has no reset; the empty flag gates pop_data, so stale entries never reach the output.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Valid/ready wrapper around a fixed-latency, non-stallable dense layer: credit-gated input, valid pipe, result FIFO.
module dense_layer_sequencer
   import dense_seq_pkg::*;
#(
   parameter int WIDTH       = 17,
   parameter int INPUT_SIZE  = 32,
   parameter int OUTPUT_SIZE = 1,
   parameter int LATENCY     = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   dense_layer_sequencer_if.slave        bus,
   output logic [WIDTH*INPUT_SIZE-1:0]   layer_in_data,
   input  logic [WIDTH*OUTPUT_SIZE-1:0]  layer_out_data,
   output logic                          busy,
   output logic [CNT_W-1:0]              out_count,
   output logic                          overflow_err
);

   localparam int OW = occ_width(FIFO_DEPTH);

   seq_state_t     state;
   seq_state_t     state_next;
   logic [LATENCY:0] vld_pipe;
   logic [OW-1:0]  inflight_cnt;
   logic [OW-1:0]  occupancy;
   logic [OW:0]    credit_used;
   logic           accept;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_drop;

   // Credits come from registered counts only, so a pop frees its slot one cycle later.
   assign credit_used   = {1'b0, inflight_cnt} + {1'b0, occupancy};
   assign bus.in_ready  = (state == RUN) && (credit_used < (OW+1)'(FIFO_DEPTH));
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = !fifo_empty;
   assign fifo_pop      = bus.out_valid && bus.out_ready;
   assign busy          = (state != IDLE);

   // Stage 0 tracks layer_in_data; the layer result for it appears LATENCY clocks later at stage LATENCY.
   assign fifo_push = vld_pipe[LATENCY];

   // NOTE: every state element updates with <= so all flops sample pre-edge values together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: the default assignment first keeps this combinational block latch-free on every path.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (enable) state_next = RUN;
         RUN:     if (!enable) state_next = DRAIN;
         DRAIN:   if (inflight_cnt == '0 && fifo_empty) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe      <= '0;
         layer_in_data <= '0;
         inflight_cnt  <= '0;
         out_count     <= '0;
         overflow_err  <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[LATENCY-1:0], accept};
         if (accept) layer_in_data <= bus.in_data;

         unique case ({accept, fifo_push})
            2'b10:   inflight_cnt <= inflight_cnt + OW'(1);
            2'b01:   inflight_cnt <= inflight_cnt - OW'(1);
            default: inflight_cnt <= inflight_cnt;
         endcase

         if (state == IDLE && state_next == RUN) out_count <= '0;
         else if (fifo_pop)                      out_count <= out_count + CNT_W'(1);

         overflow_err <= overflow_err | fifo_drop;
      end
   end

   seq_fifo #(
      .DW    (WIDTH*OUTPUT_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (layer_out_data),
      .pop       (fifo_pop),
      .pop_data  (bus.out_data),
      .occupancy (occupancy),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .drop      (fifo_drop)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed self-checking bench for dense_layer_sequencer with a 3-cycle adder model standing in for the layer.
module tb_dense_layer_sequencer;

   localparam int WIDTH       = 8;
   localparam int INPUT_SIZE  = 2;
   localparam int OUTPUT_SIZE = 1;
   localparam int LATENCY     = 3;
   localparam int FIFO_DEPTH  = 4;
   localparam int CNT_W       = 16;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic enable = 1'b0;

   logic [WIDTH*INPUT_SIZE-1:0]  layer_in_data;
   logic [WIDTH*OUTPUT_SIZE-1:0] layer_out_data;
   logic                         busy;
   logic [CNT_W-1:0]             out_count;
   logic                         overflow_err;

   logic [WIDTH-1:0] d1 = '0;
   logic [WIDTH-1:0] d2 = '0;
   logic [WIDTH-1:0] d3 = '0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int sample_idx = 0;
   int n_acc  = 0;
   int n_pop  = 0;
   int base_acc;
   int base_pop;
   logic [WIDTH-1:0] exp_q [$];
   int acc_cyc [$];

   dense_layer_sequencer_if #(
      .WIDTH       (WIDTH),
      .INPUT_SIZE  (INPUT_SIZE),
      .OUTPUT_SIZE (OUTPUT_SIZE)
   ) bus ();

   dense_layer_sequencer #(
      .WIDTH       (WIDTH),
      .INPUT_SIZE  (INPUT_SIZE),
      .OUTPUT_SIZE (OUTPUT_SIZE),
      .LATENCY     (LATENCY),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .CNT_W       (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .bus            (bus),
      .layer_in_data  (layer_in_data),
      .layer_out_data (layer_out_data),
      .busy           (busy),
      .out_count      (out_count),
      .overflow_err   (overflow_err)
   );

   always #5 clk = ~clk;

   // Dense layer stand-in: in[0] + in[1], delayed three clocks.
   always @(posedge clk) begin
      d1 <= layer_in_data[7:0] + layer_in_data[15:8];
      d2 <= d1;
      d3 <= d2;
   end
   assign layer_out_data = d3;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [15:0] sample_vec(input int n);
      logic [7:0] a;
      logic [7:0] b;
      a = 8'(n * 7 + 3);
      b = 8'(n * 5 + 1);
      return {b, a};
   endfunction

   function automatic logic [7:0] sample_sum(input int n);
      logic [15:0] v;
      v = sample_vec(n);
      return v[7:0] + v[15:8];
   endfunction

   // One clock with scoreboard bookkeeping for accepts and pops seen before the edge.
   task automatic cycle();
      logic acc;
      logic pop;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      if (pop) begin
         check("pop_has_expectation", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            check("out_data_order", 32'(bus.out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
         n_pop++;
      end
      step();
      if (acc) begin
         exp_q.push_back(sample_sum(sample_idx));
         acc_cyc.push_back(cyc);
         n_acc++;
         sample_idx++;
         bus.in_data = sample_vec(sample_idx);
      end
   endtask

   task automatic drain_outputs();
      for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.out_valid); i++) cycle();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset and idle
      repeat (3) step();
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_data", 32'(bus.out_data), 0);
      check("rst_layer_in", 32'(layer_in_data), 0);
      check("rst_out_count", 32'(out_count), 0);
      check("rst_overflow", 32'(overflow_err), 0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_in_ready", 32'(bus.in_ready), 0);
         check("idle_out_valid", 32'(bus.out_valid), 0);
         check("idle_busy", 32'(busy), 0);
         check("idle_out_count", 32'(out_count), 0);
      end

      // Single sample {5,7}
      enable = 1'b1;
      step();
      check("run_in_ready", 32'(bus.in_ready), 1);
      check("run_busy", 32'(busy), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = {8'd7, 8'd5};
      step();
      bus.in_valid = 1'b0;
      check("single_layer_in", 32'(layer_in_data), 32'h0705);
      for (int k = 0; k < 4; k++) begin
         check("single_early_valid", 32'(bus.out_valid), 0);
         step();
      end
      check("single_out_valid", 32'(bus.out_valid), 1);
      check("single_out_data", 32'(bus.out_data), 12);
      check("single_count_before_pop", 32'(out_count), 0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("single_popped", 32'(bus.out_valid), 0);
      check("single_count", 32'(out_count), 1);

      // Back-pressure
      base_acc     = n_acc;
      bus.in_data  = sample_vec(sample_idx);
      bus.in_valid = 1'b1;
      repeat (12) cycle();
      check("bp_accepts", 32'(n_acc - base_acc), 4);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_occupancy", 32'(dut.occupancy), 4);
      check("bp_overflow", 32'(overflow_err), 0);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      check("bp_blocked_at_pop", 32'(bus.in_ready), 0);
      cycle();
      check("bp_resume_ready", 32'(bus.in_ready), 1);
      check("bp_occupancy_after_pop", 32'(dut.occupancy), 3);
      cycle();
      check("bp_resume_accept", 32'(n_acc - base_acc), 5);
      bus.in_valid = 1'b0;
      drain_outputs();
      check("bp_drained", 32'(exp_q.size()), 0);

      // Stop, return to idle, restart clears the counter
      enable = 1'b0;
      for (int i = 0; i < 20 && busy; i++) cycle();
      check("stop_idle", 32'(busy), 0);
      check("count_held_in_idle", 32'(out_count), 6);
      enable = 1'b1;
      step();
      check("restart_busy", 32'(busy), 1);
      check("restart_count_clear", 32'(out_count), 0);

      // Streaming 20 samples with out_ready held high
      base_acc      = n_acc;
      base_pop      = n_pop;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 200 && (n_acc - base_acc) < 20; i++) cycle();
      bus.in_valid = 1'b0;
      check("tp_accepts", 32'(n_acc - base_acc), 20);
      check("tp_first_burst", 32'(acc_cyc[base_acc + 3] - acc_cyc[base_acc]), 3);
      drain_outputs();
      check("tp_pops", 32'(n_pop - base_pop), 20);
      check("tp_out_count", 32'(out_count), 20);
      check("tp_overflow", 32'(overflow_err), 0);

      // Drain with two samples in flight, enable re-raised mid-drain
      base_acc     = n_acc;
      bus.in_valid = 1'b1;
      repeat (2) cycle();
      check("drain_setup_accepts", 32'(n_acc - base_acc), 2);
      enable       = 1'b0;
      bus.in_valid = 1'b0;
      cycle();
      check("drain_in_ready", 32'(bus.in_ready), 0);
      check("drain_busy", 32'(busy), 1);
      enable       = 1'b1;
      bus.in_valid = 1'b1;
      base_acc     = n_acc;
      base_pop     = n_pop;
      for (int i = 0; i < 30 && busy; i++) begin
         check("drain_blocked", 32'(bus.in_ready), 0);
         cycle();
      end
      check("drain_reached_idle", 32'(busy), 0);
      check("drain_pops", 32'(n_pop - base_pop), 2);
      check("drain_no_accept", 32'(n_acc - base_acc), 0);
      check("drain_idle_blocked", 32'(bus.in_ready), 0);
      cycle();
      check("rerun_in_ready", 32'(bus.in_ready), 1);
      check("rerun_count_clear", 32'(out_count), 0);
      cycle();
      check("rerun_accept", 32'(n_acc - base_acc), 1);
      bus.in_valid = 1'b0;
      drain_outputs();
      check("rerun_drained", 32'(exp_q.size()), 0);

      // Async reset with one buffered result and three in flight
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      repeat (4) cycle();
      bus.in_valid = 1'b0;
      cycle();
      check("pre_reset_out_valid", 32'(bus.out_valid), 1);
      check("pre_reset_occupancy", 32'(dut.occupancy), 1);
      #3;
      reset = 1'b0;
      #1;
      check("arst_in_ready", 32'(bus.in_ready), 0);
      check("arst_out_valid", 32'(bus.out_valid), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_out_data", 32'(bus.out_data), 0);
      check("arst_layer_in", 32'(layer_in_data), 0);
      check("arst_out_count", 32'(out_count), 0);
      exp_q.delete();
      #2;
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("no_stale_output", 32'(bus.out_valid), 0);
      end
      check("post_reset_busy", 32'(busy), 1);
      check("final_overflow", 32'(overflow_err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
